pack_xfer_fsm: RTL and testbench
================================

// Module: pack_xfer_fsm
// PURPOSE
//  Parametrised byte-to-word transfer engine. Reads PACK consecutive IN_W-bit entries from an internal
//  source RAM and assembles them into one IN_W*PACK-bit word. Writes that word into an internal
//  destination RAM. Next generation of the fixed 8->16 transfer FSM: adds programmable base addresses,
//  word count, lane order, start/abort handshake and address wrap. Both RAMs are ram_dp_async_read.
// PARAMETERS
//  IN_W      8   source entry width (bits)
//  PACK      2   source entries per destination word (>=2)
//  SRC_DEPTH 32  source RAM depth (power of 2); SRC_AW = $clog2(SRC_DEPTH)
//  DST_DEPTH 16  destination RAM depth (power of 2); DST_AW = $clog2(DST_DEPTH)
// PORTS
//  clk        in   1            single clock, rising edge
//  rst_n      in   1            asynchronous, active-low reset
//  data_wr    in   IN_W         host write data to source RAM
//  wr_en      in   1            host write strobe to source RAM
//  wr_add     in   SRC_AW       host write address
//  rd_add     in   DST_AW       host read address, destination RAM (async)
//  data_out   out  IN_W*PACK    destination RAM read data (combinational from rd_add)
//  start      in   1            start request; accepted only in IDLE
//  abort      in   1            stop transfer; highest priority
//  src_base   in   SRC_AW       first source address
//  dst_base   in   DST_AW       first destination address
//  word_cnt   in   DST_AW+1     number of destination words to write (0..DST_DEPTH)
//  msb_first  in   1            0: first entry -> lane 0 (LSBs); 1: first entry -> lane PACK-1 (MSBs)
//  busy       out  1            high from the edge after start is accepted until the transfer ends
//  done       out  1            sticky completion flag
// BEHAVIOUR
//  - Reset: state=IDLE, busy=0, done=0, pointers/counters/assembly reg=0, dst we=0. RAM contents untouched.
//  - States: IDLE, READ, WRITE (one-hot).
//  - IDLE: start=1 at edge E0 (abort=0) latches src_base/dst_base/word_cnt/msb_first.
//    Clears done. Sets lane=0. If word_cnt==0: stays IDLE, done=1 after E0, busy stays 0.
//    Otherwise -> READ, busy=1. start is ignored while busy.
//  - READ: src read address = src_ptr (async). Each edge captures the RAM output into lane slot.
//    Slot = lane (msb_first=0) or PACK-1-lane (msb_first=1). Then src_ptr+=1 mod SRC_DEPTH (wraps).
//    After the PACK-th capture -> WRITE.
//  - WRITE: dst we=1, addr=dst_ptr, data=assembled word; the write lands at this edge.
//    Then dst_ptr+=1 mod DST_DEPTH (wraps). Words_left-=1; lane=0.
//    If words_left reaches 0: -> IDLE, busy=0, done=1. Else -> READ.
//  - Latency: N words = N*(PACK+1) cycles. The last write, busy fall and done rise all occur at edge
//    E0+N*(PACK+1).
//  - abort=1 at any edge while busy: -> IDLE, busy=0, done stays 0.
//    No write occurs at that edge, even if in WRITE. Words already written remain.
//    Aborting in IDLE has no effect. If start and abort are both high, abort wins.
//  - done: cleared only by an accepted start or by reset. It does not depend on op_mode-style level inputs.
//  - Host writes (wr_en) are allowed at any time. A READ capture sees RAM contents before that same
//    edge's host write.
//  - Host reads (rd_add) are allowed at any time. A word written at an edge is visible on data_out
//    after that edge.
// TESTING
//  1 Defaults: fill src[i]=i (0..31), start with src_base=0, dst_base=0, word_cnt=16, msb_first=0
//    -> dst[k]={2k+1,2k}, done at E0+48, busy high 48 cycles.
//  2 msb_first=1, src_base=4, dst_base=2, word_cnt=3 -> dst[2]=0x0405, dst[3]=0x0607, dst[4]=0x0809,
//    other dst entries unchanged.
//  3 Wrap: src_base=30, dst_base=15, word_cnt=2 -> dst[15]={src[31],src[30]}, dst[0]={src[1],src[0]}.
//  4 Abort in the 2nd WRITE cycle of a word_cnt=4 run -> only dst[base] written, busy=0, done=0.
//    A re-start completes normally.
//  5 word_cnt=0 -> done=1 one cycle after start, no dst writes.
//    start pulsed mid-transfer -> ignored, same completion time.
//  6 PACK=4, IN_W=8: src=0x11,0x22,0x33,0x44, msb_first=0 -> dst[0]=0x44332211, done at E0+5.
//    Async reset mid-READ -> all outputs 0 immediately.

Source files
------------

// File: rtl/pack_xfer_fsm.sv
// Packs PACK consecutive IN_W-bit source RAM entries into one destination RAM word.
// Programmable bases, word count, lane order; start/abort handshake; addresses wrap.
module pack_xfer_fsm #(
  parameter int IN_W      = 8,
  parameter int PACK      = 2,
  parameter int SRC_DEPTH = 32,
  parameter int DST_DEPTH = 16,
  localparam int SRC_AW   = $clog2(SRC_DEPTH),
  localparam int DST_AW   = $clog2(DST_DEPTH),
  localparam int OUT_W    = IN_W * PACK
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IN_W-1:0]   data_wr,
  input  logic              wr_en,
  input  logic [SRC_AW-1:0] wr_add,
  input  logic [DST_AW-1:0] rd_add,
  output logic [OUT_W-1:0]  data_out,
  input  logic              start,
  input  logic              abort,
  input  logic [SRC_AW-1:0] src_base,
  input  logic [DST_AW-1:0] dst_base,
  input  logic [DST_AW:0]   word_cnt,
  input  logic              msb_first,
  output logic              busy,
  output logic              done
);

  localparam int LW  = $clog2(PACK);
  localparam int WCW = DST_AW + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_READ  = 3'b010,
    S_WRITE = 3'b100
  } state_t;

  logic [IN_W-1:0]   r_src_mem [SRC_DEPTH];
  logic [OUT_W-1:0]  r_dst_mem [DST_DEPTH];

  state_t            r_state,      w_state_nxt;
  logic [SRC_AW-1:0] r_src_ptr,    w_src_ptr_nxt;
  logic [DST_AW-1:0] r_dst_ptr,    w_dst_ptr_nxt;
  logic [WCW-1:0]    r_words_left, w_words_left_nxt;
  logic [LW-1:0]     r_lane,       w_lane_nxt;
  logic [OUT_W-1:0]  r_asm,        w_asm_nxt;
  logic              r_msb,        w_msb_nxt;
  logic              r_done,       w_done_nxt;

  logic [LW-1:0]     w_slot;
  logic [IN_W-1:0]   w_src_rd;
  logic              w_dst_we;

  assign w_src_rd = r_src_mem[r_src_ptr];
  assign w_slot   = r_msb ? (LW'(PACK - 1) - r_lane) : r_lane;
  assign data_out = r_dst_mem[rd_add];
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;

  always_comb begin
    w_state_nxt      = r_state;
    w_src_ptr_nxt    = r_src_ptr;
    w_dst_ptr_nxt    = r_dst_ptr;
    w_words_left_nxt = r_words_left;
    w_lane_nxt       = r_lane;
    w_asm_nxt        = r_asm;
    w_msb_nxt        = r_msb;
    w_done_nxt       = r_done;
    w_dst_we         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_src_ptr_nxt    = src_base;
          w_dst_ptr_nxt    = dst_base;
          w_words_left_nxt = word_cnt;
          w_msb_nxt        = msb_first;
          w_lane_nxt       = '0;
          w_done_nxt       = (word_cnt == '0);
          if (word_cnt != '0) w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_asm_nxt[w_slot*IN_W +: IN_W] = w_src_rd;
          w_src_ptr_nxt = r_src_ptr + SRC_AW'(1);
          if (r_lane == LW'(PACK - 1)) w_state_nxt = S_WRITE;
          else                         w_lane_nxt  = r_lane + LW'(1);
        end
      end
      S_WRITE: begin
        // abort suppresses the write of the word assembled so far
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_dst_we         = 1'b1;
          w_dst_ptr_nxt    = r_dst_ptr + DST_AW'(1);
          w_words_left_nxt = r_words_left - WCW'(1);
          w_lane_nxt       = '0;
          if (r_words_left == WCW'(1)) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_READ;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_src_ptr    <= '0;
      r_dst_ptr    <= '0;
      r_words_left <= '0;
      r_lane       <= '0;
      r_asm        <= '0;
      r_msb        <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_src_ptr    <= w_src_ptr_nxt;
      r_dst_ptr    <= w_dst_ptr_nxt;
      r_words_left <= w_words_left_nxt;
      r_lane       <= w_lane_nxt;
      r_asm        <= w_asm_nxt;
      r_msb        <= w_msb_nxt;
      r_done       <= w_done_nxt;
    end
  end

  // RAM contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en)    r_src_mem[wr_add]    <= data_wr;
    if (w_dst_we) r_dst_mem[r_dst_ptr] <= r_asm;
  end

endmodule

// File: tb/tb_pack_xfer_fsm.sv
// Bench for pack_xfer_fsm: directed and randomized transfers checked against an arithmetic model.
module tb_pack_xfer_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  data_wr;
  logic        wr_en;
  logic [4:0]  wr_add;
  logic [3:0]  rd_add;
  logic [15:0] data_out;
  logic        start, abort;
  logic [4:0]  src_base;
  logic [3:0]  dst_base;
  logic [4:0]  word_cnt;
  logic        msb_first, busy, done;

  logic [7:0]  q_data_wr;
  logic        q_wr_en;
  logic [4:0]  q_wr_add;
  logic [3:0]  q_rd_add;
  logic [31:0] q_data_out;
  logic        q_start, q_abort;
  logic [4:0]  q_src_base;
  logic [3:0]  q_dst_base;
  logic [4:0]  q_word_cnt;
  logic        q_msb_first, q_busy, q_done;

  pack_xfer_fsm #(.IN_W(8), .PACK(2), .SRC_DEPTH(32), .DST_DEPTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .data_wr(data_wr), .wr_en(wr_en), .wr_add(wr_add),
    .rd_add(rd_add), .data_out(data_out), .start(start), .abort(abort),
    .src_base(src_base), .dst_base(dst_base), .word_cnt(word_cnt),
    .msb_first(msb_first), .busy(busy), .done(done)
  );

  pack_xfer_fsm #(.IN_W(8), .PACK(4), .SRC_DEPTH(32), .DST_DEPTH(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .data_wr(q_data_wr), .wr_en(q_wr_en), .wr_add(q_wr_add),
    .rd_add(q_rd_add), .data_out(q_data_out), .start(q_start), .abort(q_abort),
    .src_base(q_src_base), .dst_base(q_dst_base), .word_cnt(q_word_cnt),
    .msb_first(q_msb_first), .busy(q_busy), .done(q_done)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0]  src_m [32];
  logic [15:0] dst_m [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input int a, input logic [7:0] d);
    wr_add  = 5'(a);
    data_wr = d;
    wr_en   = 1'b1;
    step();
    wr_en    = 1'b0;
    src_m[a] = d;
  endtask

  // Expected effect of a transfer: word k takes source entries sb+2k, sb+2k+1 (mod 32)
  task automatic model_xfer(input int sb, input int db, input bit msb, input int nwords);
    for (int k = 0; k < nwords; k++) begin
      logic [15:0] w;
      w = '0;
      for (int j = 0; j < 2; j++) begin
        int sl;
        sl = msb ? 1 - j : j;
        w  = w | (16'(src_m[(sb + k*2 + j) % 32]) << (8*sl));
      end
      dst_m[(db + k) % 16] = w;
    end
  endtask

  task automatic check_dst(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_add = 4'(i);
      #1;
      chk($sformatf("%s.dst%0d", tag, i), 32'(data_out), 32'(dst_m[i]));
    end
  endtask

  task automatic run_xfer(input string tag, input int sb, input int db, input int n,
                          input bit msb, input int poke);
    int cyc, bc;
    src_base  = 5'(sb);
    dst_base  = 4'(db);
    word_cnt  = 5'(n);
    msb_first = msb;
    start     = 1'b1;
    step();
    start     = 1'b0;
    src_base  = 5'($urandom);
    dst_base  = 4'($urandom);
    word_cnt  = 5'($urandom_range(16, 1));
    msb_first = 1'($urandom);
    cyc = 0;
    bc  = 0;
    while (!done && cyc < 400) begin
      if (busy) bc++;
      start = (cyc == poke);
      step();
      cyc++;
    end
    start = 1'b0;
    chk({tag, ".cycles"}, 32'(cyc), 32'(n*3));
    chk({tag, ".busy_cycles"}, 32'(bc), 32'(n*3));
    chk({tag, ".busy_end"}, 32'(busy), 32'd0);
    chk({tag, ".done_end"}, 32'(done), 32'd1);
    model_xfer(sb, db, msb, n);
    check_dst(tag);
  endtask

  initial begin
    int cyc;
    data_wr = '0; wr_en = 1'b0; wr_add = '0; rd_add = '0;
    start = 1'b0; abort = 1'b0; src_base = '0; dst_base = '0; word_cnt = '0; msb_first = 1'b0;
    q_data_wr = '0; q_wr_en = 1'b0; q_wr_add = '0; q_rd_add = '0;
    q_start = 1'b0; q_abort = 1'b0; q_src_base = '0; q_dst_base = '0; q_word_cnt = '0;
    q_msb_first = 1'b0;

    #12;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.q_busy", 32'(q_busy), 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 32; i++) host_wr(i, 8'(i));
    run_xfer("t1", 0, 0, 16, 1'b0, -1);
    rd_add = 4'd5; #1;
    chk("t1.d5", 32'(data_out), 32'h0b0a);

    run_xfer("t2", 4, 2, 3, 1'b1, -1);
    rd_add = 4'd2; #1;
    chk("t2.d2", 32'(data_out), 32'h0405);
    rd_add = 4'd4; #1;
    chk("t2.d4", 32'(data_out), 32'h0809);

    run_xfer("t3", 30, 15, 2, 1'b0, -1);
    rd_add = 4'd15; #1;
    chk("t3.d15", 32'(data_out), 32'h1f1e);
    rd_add = 4'd0; #1;
    chk("t3.d0", 32'(data_out), 32'h0100);

    // abort at the edge of the second word's write
    src_base = 5'd9; dst_base = 4'd5; word_cnt = 5'd4; msb_first = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t4.busy", 32'(busy), 32'd0);
    chk("t4.done", 32'(done), 32'd0);
    repeat (3) step();
    model_xfer(9, 5, 1'b0, 1);
    check_dst("t4");

    run_xfer("t5zero", 3, 7, 0, 1'b0, -1);
    run_xfer("t4re", 9, 5, 4, 1'b1, -1);

    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("sa.busy", 32'(busy), 32'd0);
    chk("sa.done", 32'(done), 32'd1);

    run_xfer("t5poke", 11, 3, 5, 1'b1, 7);

    for (int r = 0; r < 6; r++) begin
      repeat (8) host_wr(int'($urandom_range(31, 0)), 8'($urandom));
      run_xfer($sformatf("rnd%0d", r), int'($urandom_range(31, 0)), int'($urandom_range(15, 0)),
               int'($urandom_range(16, 1)), 1'($urandom), int'($urandom_range(20, 0)) - 4);
    end

    for (int i = 0; i < 4; i++) begin
      q_wr_add  = 5'(i);
      q_data_wr = 8'(8'h11 * (i + 1));
      q_wr_en   = 1'b1;
      step();
    end
    q_wr_en = 1'b0;
    q_word_cnt = 5'd1;
    q_start = 1'b1;
    step();
    q_start = 1'b0;
    cyc = 0;
    while (!q_done && cyc < 100) begin
      step();
      cyc++;
    end
    chk("t6.cycles", 32'(cyc), 32'd5);
    q_rd_add = 4'd0; #1;
    chk("t6.d0", q_data_out, 32'h44332211);

    q_word_cnt = 5'd2;
    q_start = 1'b1;
    step();
    q_start = 1'b0;
    step();
    #2;
    chk("t6.busy_pre", 32'(q_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6.rst_busy", 32'(q_busy), 32'd0);
    chk("t6.rst_done", 32'(q_done), 32'd0);
    chk("t6.rst_done_p2", 32'(done), 32'd0);
    #10;
    rst_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
